// File: rtl/mult_share_pkg.sv
// Shared definitions for mult_share_arbiter: FSM state encoding, watchdog limit,
// and bit positions inside a {a_signed, b_signed} sign_mode pair.
package mult_share_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StResp  = 2'd3;

  // Last WAIT cycle count before the watchdog gives up (6-bit counter).
  localparam logic [5:0] TIMEOUT_LIMIT = 6'd63;

  localparam int unsigned SIGN_A_BIT = 1;
  localparam int unsigned SIGN_B_BIT = 0;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past last_grant
// and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned w_idx;

  // First requester found after last_grant (wrapping) wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_idx = 32'(last_grant) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!grant_valid && req[w_idx[IDX_W-1:0]]) begin
        grant[w_idx[IDX_W-1:0]] = 1'b1;
        grant_idx               = w_idx[IDX_W-1:0];
        grant_valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external multiplier between NUM_REQ requesters. One operation is in
// flight at a time: accept -> issue start pulse -> wait for done -> hold response.
// Optional feature: define MULT_SHARE_TIMEOUT_EN to add a WAIT-state watchdog that
// returns an error response if the multiplier never signals done.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ*2-1:0]         req_sign_mode,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_multiplicand,
  output logic [WIDTH-1:0]             mul_multiplier,
  output logic [1:0]                   mul_sign_mode,
  input  logic [2*WIDTH-1:0]           mul_product,
  input  logic                         mul_done,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [2*WIDTH-1:0]           resp_product,
  output logic                         resp_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_sign;
  logic [2*WIDTH-1:0] r_product;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic               w_accept;
  logic               w_timeout;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [1:0]         w_sel_sign;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // Grants only exist on valid bits, so any grant in IDLE is a transfer.
  assign w_accept  = (r_state == StIdle) && w_grant_valid;
  assign req_ready = (r_state == StIdle) ? w_grant : '0;

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_sign = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a    = req_a[i*WIDTH +: WIDTH];
        w_sel_b    = req_b[i*WIDTH +: WIDTH];
        w_sel_sign = req_sign_mode[i*2 +: 2];
      end
    end
  end

`ifdef MULT_SHARE_TIMEOUT_EN
  logic [5:0] r_wd_cnt;
  logic       r_resp_err;

  assign w_timeout = (r_wd_cnt == TIMEOUT_LIMIT);
  assign resp_err  = r_resp_err;

  // Watchdog: cleared while issuing, counts each WAIT cycle without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == StIssue) begin
      r_wd_cnt <= '0;
    end else if (r_state == StWait && !mul_done && !w_timeout) begin
      r_wd_cnt <= r_wd_cnt + 6'd1;
    end
  end

  // Error flag: done wins over a simultaneous timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_err <= 1'b0;
    end else if (r_state == StWait) begin
      if (mul_done)       r_resp_err <= 1'b0;
      else if (w_timeout) r_resp_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // Next-state logic; mul_done outside WAIT is ignored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (mul_done || w_timeout) w_state_next = StResp;
      StResp:  if (resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Transaction latches and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sign       <= '0;
      r_product    <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_id         <= w_grant_idx;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_sign       <= w_sel_sign;
      end
      if (r_state == StWait) begin
        if (mul_done)       r_product <= mul_product;
        else if (w_timeout) r_product <= '0;
      end
    end
  end

  assign mul_start        = (r_state == StIssue);
  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;
  assign mul_sign_mode    = {r_sign[SIGN_A_BIT], r_sign[SIGN_B_BIT]};
  assign resp_valid       = (r_state == StResp);
  assign resp_id          = r_id;
  assign resp_product     = r_product;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized self-checking bench for mult_share_arbiter. The bench plays the
// multiplier and predicts grants/products from a transaction-level model.
// Honors MULT_SHARE_TIMEOUT_EN to pick the expected watchdog behaviour.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [7:0]  req_sign_mode = '0;
  logic        mul_start;
  logic [15:0] mul_multiplicand;
  logic [15:0] mul_multiplier;
  logic [1:0]  mul_sign_mode;
  logic [31:0] mul_product = '0;
  logic        mul_done = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_id;
  logic [31:0] resp_product;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = NUM_REQ - 1;

  logic [3:0]  obs_ready;
  logic [1:0]  obs_id;
  logic [31:0] obs_prod;
  logic        obs_err;

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_sign_mode    (req_sign_mode),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_sign_mode    (mul_sign_mode),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_id          (resp_id),
    .resp_product     (resp_product),
    .resp_err         (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next requester after m_last holding a request, or -1.
  function automatic int model_grant(input logic [3:0] mask);
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (m_last + off) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // sm = {a_signed, b_signed}; product truncated to 2*WIDTH.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] sm);
    longint sa, sb;
    sa = sm[1] ? longint'($signed(a)) : longint'(a);
    sb = sm[0] ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; mul_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = NUM_REQ - 1;
  endtask

  task automatic run_txn(input logic [3:0] mask, input int lat, input int rdly, input bit rnd);
    int g;
    logic [15:0] a, b;
    logic [1:0]  sm;
    logic [31:0] p;
    @(negedge clk);
    if (rnd) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_sign_mode = 8'($urandom);
    end
    req_valid = mask; resp_ready = 1'b0; mul_done = 1'b0;
    #1;
    g = model_grant(mask);
    obs_ready = req_ready;
    check_eq("grant", 64'(req_ready), 64'(4'b0001 << g));
    m_last = g;
    a  = req_a[g*16 +: 16];
    b  = req_b[g*16 +: 16];
    sm = req_sign_mode[g*2 +: 2];
    p  = ref_mul(a, b, sm);
    // Scramble inputs: the block must work from its own latches from here on.
    @(negedge clk);
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_sign_mode = 8'($urandom);
    #1;
    check_eq("issue_start", 64'(mul_start), 64'd1);
    check_eq("issue_a", 64'(mul_multiplicand), 64'(a));
    check_eq("issue_b", 64'(mul_multiplier), 64'(b));
    check_eq("issue_sign", 64'(mul_sign_mode), 64'(sm));
    check_eq("issue_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      check_eq("wait_start", 64'(mul_start), 64'd0);
      check_eq("wait_a", 64'(mul_multiplicand), 64'(a));
      check_eq("wait_busy", 64'({resp_valid, req_ready}), 64'd0);
    end
    @(negedge clk);
    mul_done = 1'b1; mul_product = p;
    #1;
    check_eq("done_b", 64'(mul_multiplier), 64'(b));
    @(negedge clk);
    mul_done = 1'b0; mul_product = $urandom;
    #1;
    obs_id = resp_id; obs_prod = resp_product; obs_err = resp_err;
    check_eq("resp_valid", 64'(resp_valid), 64'd1);
    check_eq("resp_id", 64'(resp_id), 64'(g));
    check_eq("resp_prod", 64'(resp_product), 64'(p));
    check_eq("resp_err", 64'(resp_err), 64'd0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      mul_done = 1'($urandom); mul_product = $urandom;
      #1;
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_id", 64'(resp_id), 64'(g));
      check_eq("hold_prod", 64'(resp_product), 64'(p));
      check_eq("hold_quiet", 64'({mul_start, req_ready}), 64'd0);
    end
    @(negedge clk);
    mul_done = 1'b0; resp_ready = 1'b1;
    #1;
    check_eq("acc_valid", 64'(resp_valid), 64'd1);
    check_eq("acc_no_grant", 64'(req_ready), 64'd0);
    @(negedge clk);
    resp_ready = 1'b0; req_valid = '0;
    #1;
    check_eq("post_valid", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int g, n;
    bit seen;
    logic [3:0] mask;

    // Reset state.
    do_reset();
    #1;
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_start", 64'(mul_start), 64'd0);
    check_eq("rst_prod", 64'(resp_product), 64'd0);
    check_eq("rst_id", 64'(resp_id), 64'd0);
    check_eq("rst_err", 64'(resp_err), 64'd0);
    check_eq("rst_ops", 64'({mul_multiplicand, mul_multiplier}), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);

    // Unsigned max * max from requester 0.
    req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'hFFFF; req_sign_mode[1:0] = 2'b00;
    run_txn(4'b0001, 3, 0, 1'b0);
    check_eq("u_id", 64'(obs_id), 64'd0);
    check_eq("u_prod", 64'(obs_prod), 64'hFFFE0001);
    check_eq("u_err", 64'(obs_err), 64'd0);

    // Signed -1 * 3 from requester 2.
    req_a[47:32] = 16'hFFFF; req_b[47:32] = 16'h0003; req_sign_mode[5:4] = 2'b11;
    run_txn(4'b0100, 1, 1, 1'b0);
    check_eq("s_id", 64'(obs_id), 64'd2);
    check_eq("s_prod", 64'(obs_prod), 64'hFFFFFFFD);

    // All requesters held: rotation 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b1111, 0, 0, 1'b1);
      check_eq("rr_order", 64'(obs_ready), 64'(4'b0001 << order[k]));
    end

    // Back-pressure for five cycles in RESP.
    run_txn(4'b1111, 2, 5, 1'b1);

    // Reset mid-WAIT aborts; requester 0 wins next.
    @(negedge clk);
    req_valid = 4'b1010; #1;
    g = model_grant(4'b1010);
    check_eq("abort_grant", 64'(req_ready), 64'(4'b0001 << g));
    m_last = g;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_last = NUM_REQ - 1;
    #1;
    check_eq("abort_valid", 64'(resp_valid), 64'd0);
    check_eq("abort_start", 64'(mul_start), 64'd0);
    run_txn(4'b1111, 2, 0, 1'b1);
    check_eq("abort_next_id", 64'(obs_id), 64'd0);

    // Random traffic.
    for (int k = 0; k < 25; k++) begin
      mask = 4'($urandom_range(1, 15));
      run_txn(mask, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Multiplier never answers.
    @(negedge clk);
    req_valid = 4'b0010; #1;
    g = model_grant(4'b0010);
    check_eq("to_grant", 64'(req_ready), 64'(4'b0001 << g));
    m_last = g;
    @(negedge clk);
    req_valid = '0; #1;
    check_eq("to_start", 64'(mul_start), 64'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); #1;
      n++;
      if (resp_valid) seen = 1'b1;
    end
`ifdef MULT_SHARE_TIMEOUT_EN
    check_eq("to_seen", 64'(seen), 64'd1);
    check_eq("to_cycles", 64'(n - 1), 64'd64);
    check_eq("to_err", 64'(resp_err), 64'd1);
    check_eq("to_prod", 64'(resp_product), 64'd0);
    @(negedge clk); resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
`else
    check_eq("no_to_resp", 64'(seen), 64'd0);
`endif
    do_reset();
    run_txn(4'b1111, 1, 0, 1'b1);
    check_eq("final_id", 64'(obs_id), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
